pwm_duty_sched: RTL and testbench

//  Sequences the 11-bit duty fed to the PWM generator. Duty changes only at PWM period boundaries.

---
 rtl/pwm_sched_pkg.sv | 5 +
 rtl/pwm_duty_sched_ovr_monitor.sv | 62 ++++++
 rtl/pwm_duty_sched.sv | 114 +++++++++++
 tb/tb_pwm_duty_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and defaults for the PWM duty scheduler.
package pwm_sched_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, RUN, FAULT} state_t;
  localparam int DUTY_W_DEF = 11;
endpackage

// File: rtl/pwm_duty_sched_ovr_monitor.sv
// Over-current monitor: synchronises the raw comparator, remembers an event
// seen during the current PWM period, and counts consecutive periods with an
// event. trip is raised combinationally on the synch edge that brings the
// count up to OVR_LIMIT.
module ovr_monitor #(
  parameter int OVR_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic OVR_I,
  input  logic OVR_I_blank_n,
  input  logic PWM_synch,
  input  logic clr,
  output logic trip
);
  localparam int CW = $clog2(OVR_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(OVR_LIMIT);

  logic [1:0]    sync_q;
  logic          seen_q, seen_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ev;

  // Only sense inside the unblanked window; sync_q[1] is the settled sample.
  assign ev = sync_q[1] & OVR_I_blank_n;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], OVR_I};
  end

  // Per-period event flag and saturating consecutive-period counter.
  // An event coincident with the synch pulse belongs to the ending period.
  always_comb begin
    seen_d = seen_q;
    cnt_d  = cnt_q;
    if (clr) begin
      seen_d = 1'b0;
      cnt_d  = '0;
    end else if (PWM_synch) begin
      seen_d = 1'b0;
      if (seen_q | ev) cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
      else             cnt_d = '0;
    end else if (ev) begin
      seen_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  assign trip = ~clr & PWM_synch & (cnt_d == LIM);
endmodule

// File: rtl/pwm_duty_sched.sv
// PWM duty scheduler: slew-limited duty sequencing aligned to PWM period
// boundaries, ramp-down on disable, and a latched over-current fault.
module pwm_duty_sched
  import pwm_sched_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int SLEW      = 16,
  parameter int DUTY_MAX  = 2000,
  parameter int OVR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty_req,
  input  logic              PWM_synch,
  input  logic              OVR_I_blank_n,
  input  logic              OVR_I,
  input  logic              clr_fault,
  output logic [DUTY_W-1:0] duty,
  output logic              ramping,
  output logic              at_target,
  output logic              fault
);
  localparam logic [DUTY_W-1:0] DMAX   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] SLEW_D = DUTY_W'(SLEW);
  localparam logic [DUTY_W:0]   SLEW_M = (DUTY_W+1)'(SLEW);

  state_t                state_q, state_d;
  logic [DUTY_W-1:0]     duty_q, duty_d;
  logic                  fault_q, fault_d;
  logic [DUTY_W-1:0]     target, step_val;
  logic signed [DUTY_W:0] diff;
  logic [DUTY_W:0]       mag;
  logic                  land, trip;

  // Counting is frozen (and held clear) while latched in FAULT.
  ovr_monitor #(.OVR_LIMIT(OVR_LIMIT)) u_ovr (
    .clk           (clk),
    .rst_n         (rst_n),
    .OVR_I         (OVR_I),
    .OVR_I_blank_n (OVR_I_blank_n),
    .PWM_synch     (PWM_synch),
    .clr           (state_q == FAULT),
    .trip          (trip)
  );

  // Clamped target and one slew-limited step toward it. The extra sign bit
  // keeps the difference from wrapping; the step itself cannot under/overflow
  // because it is only taken when the target is more than SLEW away.
  assign target   = en ? ((duty_req > DMAX) ? DMAX : duty_req) : '0;
  assign diff     = $signed({1'b0, target}) - $signed({1'b0, duty_q});
  assign mag      = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
  assign land     = (mag <= SLEW_M);
  assign step_val = land ? target :
                    (diff[DUTY_W] ? duty_q - SLEW_D : duty_q + SLEW_D);

  // State, duty and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      fault_q <= fault_d;
    end
  end

  // Next state and duty; a trip overrides everything, without a synch wait.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    fault_d = fault_q;
    if (trip) begin
      state_d = FAULT;
      duty_d  = '0;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          duty_d = '0;
          if (en) state_d = RAMP;
        end
        RAMP: if (PWM_synch) begin
          duty_d = step_val;
          // Landing with en low means the target (and so the result) is 0.
          if (land) state_d = en ? RUN : IDLE;
        end
        RUN: begin
          if (PWM_synch) duty_d = step_val;
          if (!en || (PWM_synch && !land)) state_d = RAMP;
        end
        FAULT: begin
          duty_d = '0;
          if (clr_fault && !en) begin
            state_d = IDLE;
            fault_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    ramping   = (state_q == RAMP);
    at_target = (state_q == RUN) && (duty_q == target);
  end

  assign duty  = duty_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_pwm_duty_sched.sv
// Self-checking bench: directed scenarios plus a randomized phase, every cycle
// compared against an integer-arithmetic reference model of the scheduler.
module tb_pwm_duty_sched;
  localparam int SLEW = 16;
  localparam int DMAX = 2000;
  localparam int LIM  = 3;
  localparam int S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n, en, PWM_synch, OVR_I_blank_n, OVR_I, clr_fault;
  logic [10:0] duty_req, duty;
  logic        ramping, at_target, fault;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_duty_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_req(duty_req),
    .PWM_synch(PWM_synch), .OVR_I_blank_n(OVR_I_blank_n), .OVR_I(OVR_I),
    .clr_fault(clr_fault), .duty(duty), .ramping(ramping),
    .at_target(at_target), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int       m_st, m_duty, m_cnt;
  bit       m_seen, m_fault;
  bit [1:0] m_sync;

  function automatic int tgt_f();
    int r;
    r = int'(duty_req);
    if (r > DMAX) r = DMAX;
    return en ? r : 0;
  endfunction

  task automatic model_step();
    int  t, d, nd, nst, ncnt;
    bit  ev, trip, land, nseen, nfault;
    t      = tgt_f();
    d      = t - m_duty;
    land   = (d <= SLEW) && (d >= -SLEW);
    nd     = m_duty; nst = m_st; nfault = m_fault;
    ncnt   = m_cnt;  nseen = m_seen; trip = 0;
    ev     = m_sync[1] && OVR_I_blank_n;
    if (m_st == S_FAULT) begin
      ncnt = 0; nseen = 0;
    end else if (PWM_synch) begin
      ncnt  = (m_seen || ev) ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
      nseen = 0;
      trip  = (ncnt == LIM);
    end else if (ev) begin
      nseen = 1;
    end
    if (trip) begin
      nst = S_FAULT; nd = 0; nfault = 1;
    end else begin
      case (m_st)
        S_IDLE: begin nd = 0; if (en) nst = S_RAMP; end
        S_RAMP: if (PWM_synch) begin
          nd = land ? t : (d > 0 ? m_duty + SLEW : m_duty - SLEW);
          if (land) nst = en ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          if (PWM_synch) nd = land ? t : (d > 0 ? m_duty + SLEW : m_duty - SLEW);
          if (!en || (PWM_synch && !land)) nst = S_RAMP;
        end
        default: begin
          nd = 0;
          if (clr_fault && !en) begin nst = S_IDLE; nfault = 0; end
        end
      endcase
    end
    m_sync = {m_sync[0], OVR_I};
    m_st = nst; m_duty = nd; m_fault = nfault; m_cnt = ncnt; m_seen = nseen;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_duty = 0; m_cnt = 0; m_seen = 0; m_fault = 0; m_sync = '0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole-output compare against the model: {duty, fault, ramping, at_target}.
  task automatic chk_model();
    logic [31:0] g, e;
    g = {17'd0, duty, fault, ramping, at_target};
    e = {17'd0, 11'(m_duty), m_fault, (m_st == S_RAMP),
         (m_st == S_RUN) && (m_duty == tgt_f())};
    chk("model", g, e);
  endtask

  task automatic cyc();
    @(negedge clk);
    chk_model();
  endtask

  // One PWM period ending in a synch pulse. mode 0: quiet, 1: unblanked
  // over-current pulse, 2: pulse fully inside a blanking window (len >= 12).
  task automatic period(input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      OVR_I         = (mode != 0) && (i >= 2) && (i <= 4);
      OVR_I_blank_n = !((mode == 2) && (i >= 1) && (i <= 9));
      PWM_synch     = (i == len - 1);
      cyc();
    end
    PWM_synch = 0; OVR_I = 0; OVR_I_blank_n = 1;
  endtask

  function automatic int plen();
    return int'($urandom_range(8, 14));
  endfunction

  initial begin
    int exp1 [7] = '{16, 32, 48, 64, 80, 96, 100};
    int k, e;
    rst_n = 0; en = 0; duty_req = '0; PWM_synch = 0;
    OVR_I_blank_n = 1; OVR_I = 0; clr_fault = 0;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_flags", {ramping, at_target, fault}, 0);
    rst_n = 1;
    cyc();

    // Ramp up to 100.
    en = 1; duty_req = 11'd100;
    for (int i = 0; i < 7; i++) begin
      period(plen(), 0);
      chk("ramp_up", duty, exp1[i]);
    end
    chk("run_at_target", {ramping, at_target}, 2'b01);

    // Clamp to DUTY_MAX, then track a small step down.
    duty_req = 11'd2047;
    for (int i = 1; i <= 119; i++) begin
      period(plen(), 0);
      e = 100 + 16 * i;
      if (e > DMAX) e = DMAX;
      chk("clamp_ramp", duty, e);
    end
    chk("clamp_run", {ramping, at_target}, 2'b01);
    period(plen(), 0);
    chk("clamp_hold", duty, 2000);
    duty_req = 11'd1990;
    period(plen(), 0);
    chk("track_1990", duty, 1990);
    chk("track_run", {ramping, at_target}, 2'b01);

    // Walk down to 40, then disable.
    duty_req = 11'd40;
    k = 0;
    while (duty != 11'd40 && k < 200) begin period(plen(), 0); k++; end
    chk("reach_40", duty, 40);
    period(plen(), 0);
    chk("run_40", at_target, 1);
    en = 0;
    period(plen(), 0);
    chk("dis_24", duty, 24);
    repeat (3) cyc();
    chk("dis_hold", duty, 24);
    period(plen(), 0);
    chk("dis_8", duty, 8);
    period(plen(), 0);
    chk("dis_0", duty, 0);
    chk("dis_idle", {ramping, at_target}, 0);

    // Over-current only inside blanking: never counts.
    for (int i = 0; i < 10; i++) period(14, 2);
    chk("blank_nofault", fault, 0);
    // Two real pulses afterwards still fall short, so the count stayed 0.
    period(plen(), 1); period(plen(), 1);
    chk("blank_cnt0", fault, 0);
    period(plen(), 0);

    // Trip: a clean period breaks the run, three in a row trip.
    en = 1; duty_req = 11'd100;
    for (int i = 0; i < 8; i++) period(plen(), 0);
    chk("pre_trip_duty", duty, 100);
    period(plen(), 1); period(plen(), 1); period(plen(), 0);
    period(plen(), 1); period(plen(), 1);
    chk("no_trip", fault, 0);
    chk("no_trip_duty", duty, 100);
    period(plen(), 1);
    chk("trip_fault", fault, 1);
    chk("trip_duty", duty, 0);

    // Clear: ignored while enabled, honoured when disabled.
    clr_fault = 1; cyc(); clr_fault = 0; cyc();
    chk("clr_ignored", fault, 1);
    period(plen(), 0);
    chk("fault_duty0", duty, 0);
    en = 0; cyc();
    clr_fault = 1; cyc(); clr_fault = 0; cyc();
    chk("clr_done", {fault, ramping}, 0);

    // Async reset in the middle of a ramp.
    en = 1; duty_req = 11'd500;
    cyc();
    for (int i = 0; i < 3; i++) period(plen(), 0);
    chk("pre_rst_duty", duty, 48);
    repeat (2) cyc();
    #2 rst_n = 0;
    #1 chk("async_rst_duty", duty, 0);
    chk("async_rst_flags", {ramping, at_target, fault}, 0);
    @(negedge clk);
    rst_n = 1; en = 0;
    cyc();

    // Randomized phase, checked every cycle against the model.
    for (int p = 0; p < 220; p++) begin
      int mode, r;
      r = int'($urandom_range(0, 99));
      if (r < 12)      en = 0;
      else if (r < 80) en = 1;
      if ($urandom_range(0, 3) == 0) duty_req = 11'($urandom_range(0, 2047));
      r = int'($urandom_range(0, 99));
      mode = (r < 55) ? 0 : (r < 85) ? 1 : 2;
      clr_fault = ($urandom_range(0, 4) == 0);
      period(int'($urandom_range(12, 18)), mode);
      clr_fault = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
